mem_arbiter: RTL and testbench

//  Shares the single synchronous-read main RAM between two requesters:

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter_starve_counter.sv | 43 ++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the main-RAM arbiter slice.
//  - ADDR_W_DEF / DATA_W_DEF : default RAM word-address and data widths
//  - ST_*                    : arbiter FSM state encodings
//  - PORT_*                  : requester ids (CPU path, debug/loader path)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

   localparam int ADDR_W_DEF = 9;
   localparam int DATA_W_DEF = 32;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RDATA  = 2'd2;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// One requester port of the RAM arbiter.
//  req    requester -> arbiter  request, held with we/addr/wdata until gnt
//  we     requester -> arbiter  1 = write, 0 = read
//  addr   requester -> arbiter  word address
//  wdata  requester -> arbiter  write data
//  gnt    arbiter -> requester  1-cycle pulse, access issued to RAM
//  rvalid arbiter -> requester  1-cycle pulse, rdata valid (reads only)
//  rdata  arbiter -> requester  read data, holds last value read by this port
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// mem_arbiter_starve_counter
// Counts consecutive arbitration losses of the debug port; saturates at LIMIT.
//  clk       in   clock, rising edge
//  in_reset  in   asynchronous, active-low reset (count -> 0)
//  clr       in   clear count (debug port won or stopped requesting)
//  inc       in   increment (both requested, CPU port won)
//  at_limit  out  count == LIMIT, debug port must win the next contention
// -----------------------------------------------------------------------------
module mem_arbiter_starve_counter #(
   parameter int LIMIT = 4,
   parameter int CNT_W = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic in_reset,
   input  logic clr,
   input  logic inc,
   output logic at_limit
);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   assign at_limit = (cnt_reg == CNT_W'(LIMIT));

   always_comb begin
      cnt_next = cnt_reg;
      if (clr) begin
         cnt_next = '0;
      end else if (inc && !at_limit) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge in_reset) begin
      if (!in_reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one synchronous-read RAM between the CPU memory path (p0) and the
// debug/program-loader port (p1). One access at a time; p0 has fixed priority,
// a starvation counter forces p1 to win after STARVE_LIM consecutive losses.
//  clk        in   clock, rising edge
//  in_reset   in   asynchronous, active-low reset
//  p0, p1     requester ports (mem_arbiter_if.slave)
//  mem_addr   out  RAM address
//  mem_wdata  out  RAM write data
//  mem_we     out  RAM write strobe
//  mem_re     out  RAM read strobe, mem_rdata valid on the next cycle
//  mem_rdata  in   RAM read data
//  busy       out  arbiter not idle
// Timing: req sampled in IDLE at edge N -> gnt in cycle N+1, rvalid in N+2.
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              in_reset,
   mem_arbiter_if.slave      p0,
   mem_arbiter_if.slave      p1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);

   logic [1:0]        state_reg,     state_next;
   logic              lat_we_reg,    lat_we_next;
   logic              lat_port_reg,  lat_port_next;
   logic [ADDR_W-1:0] lat_addr_reg,  lat_addr_next;
   logic [DATA_W-1:0] lat_wdata_reg, lat_wdata_next;

   logic [1:0]        req_vec;
   logic [1:0]        gnt_vec;
   logic [1:0]        rvalid_vec;
   logic [DATA_W-1:0] rdata_vec [2];

   logic idle;
   logic win_dbg;
   logic at_limit;
   logic cnt_clr;
   logic cnt_inc;

   assign req_vec = {p1.req, p0.req};
   assign idle    = (state_reg == ST_IDLE);

   // p1 wins when alone, or when contending after STARVE_LIM straight losses.
   assign win_dbg = req_vec[1] && (!req_vec[0] || at_limit);

   // Counter only moves on IDLE cycles; requests elsewhere are ignored.
   assign cnt_clr = idle && (!req_vec[1] || win_dbg);
   assign cnt_inc = idle && req_vec[0] && req_vec[1] && !win_dbg;

   mem_arbiter_starve_counter #(
      .LIMIT (STARVE_LIM),
      .CNT_W (CNT_W)
   ) u_starve (
      .clk      (clk),
      .in_reset (in_reset),
      .clr      (cnt_clr),
      .inc      (cnt_inc),
      .at_limit (at_limit)
   );

   always_comb begin
      state_next     = state_reg;
      lat_we_next    = lat_we_reg;
      lat_port_next  = lat_port_reg;
      lat_addr_next  = lat_addr_reg;
      lat_wdata_next = lat_wdata_reg;
      case (state_reg)
         ST_IDLE: begin
            if (|req_vec) begin
               state_next = ST_ACCESS;
               if (win_dbg) begin
                  lat_port_next  = PORT_DBG;
                  lat_we_next    = p1.we;
                  lat_addr_next  = p1.addr;
                  lat_wdata_next = p1.wdata;
               end else begin
                  lat_port_next  = PORT_CPU;
                  lat_we_next    = p0.we;
                  lat_addr_next  = p0.addr;
                  lat_wdata_next = p0.wdata;
               end
            end
         end
         ST_ACCESS: state_next = lat_we_reg ? ST_IDLE : ST_RDATA;
         ST_RDATA:  state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge in_reset) begin
      if (!in_reset) begin
         state_reg     <= ST_IDLE;
         lat_we_reg    <= 1'b0;
         lat_port_reg  <= PORT_CPU;
         lat_addr_reg  <= '0;
         lat_wdata_reg <= '0;
      end else begin
         state_reg     <= state_next;
         lat_we_reg    <= lat_we_next;
         lat_port_reg  <= lat_port_next;
         lat_addr_reg  <= lat_addr_next;
         lat_wdata_reg <= lat_wdata_next;
      end
   end

   // RAM side: strobes only in ACCESS, address/data straight from the latch.
   assign mem_addr  = lat_addr_reg;
   assign mem_wdata = lat_wdata_reg;
   assign mem_we    = (state_reg == ST_ACCESS) &&  lat_we_reg;
   assign mem_re    = (state_reg == ST_ACCESS) && !lat_we_reg;
   assign busy      = !idle;

   // Per-port grant/rvalid decode and read-data hold register.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         logic [DATA_W-1:0] hold_reg;

         assign gnt_vec[gi]    = (state_reg == ST_ACCESS) && (lat_port_reg == 1'(gi));
         assign rvalid_vec[gi] = (state_reg == ST_RDATA)  && (lat_port_reg == 1'(gi));

         always_ff @(posedge clk or negedge in_reset) begin
            if (!in_reset) begin
               hold_reg <= '0;
            end else if (rvalid_vec[gi]) begin
               hold_reg <= mem_rdata;
            end
         end

         // During rvalid the RAM output is passed through so data arrives
         // in the same cycle; afterwards the captured copy is presented.
         assign rdata_vec[gi] = rvalid_vec[gi] ? mem_rdata : hold_reg;
      end
   endgenerate

   assign p0.gnt    = gnt_vec[0];
   assign p0.rvalid = rvalid_vec[0];
   assign p0.rdata  = rdata_vec[0];
   assign p1.gnt    = gnt_vec[1];
   assign p1.rvalid = rvalid_vec[1];
   assign p1.rdata  = rdata_vec[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Bench for mem_arbiter: directed scenarios plus random two-port traffic.
// A reference model decides grants from the arbitration rules and queues the
// expected accesses; a monitor compares DUT activity against that queue.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW  = 9;
   localparam int DW  = 32;
   localparam int LIM = 4;

   typedef struct {
      int          cyc;
      int          port;
      bit          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic in_reset = 1'b0;
   always #5 clk = ~clk;

   // requester drive
   logic          p_req   [2];
   logic          p_we    [2];
   logic [AW-1:0] p_addr  [2];
   logic [DW-1:0] p_wdata [2];
   logic          gnt     [2];
   logic          rvalid  [2];
   logic [DW-1:0] rdata   [2];

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          mem_re;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

   assign if0.req   = p_req[0];
   assign if0.we    = p_we[0];
   assign if0.addr  = p_addr[0];
   assign if0.wdata = p_wdata[0];
   assign if1.req   = p_req[1];
   assign if1.we    = p_we[1];
   assign if1.addr  = p_addr[1];
   assign if1.wdata = p_wdata[1];
   assign gnt[0]    = if0.gnt;
   assign gnt[1]    = if1.gnt;
   assign rvalid[0] = if0.rvalid;
   assign rvalid[1] = if1.rvalid;
   assign rdata[0]  = if0.rdata;
   assign rdata[1]  = if1.rdata;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) u_dut (
      .clk       (clk),
      .in_reset  (in_reset),
      .p0        (if0),
      .p1        (if1),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   // Synchronous-read RAM behind the arbiter, preloaded through ld_*.
   logic [DW-1:0] ram [512];
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;

   always @(posedge clk) begin
      if (ld_en) begin
         ram[ld_addr] <= ld_data;
      end else begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         if (mem_re) mem_rdata <= ram[mem_addr];
      end
   end

   // ---------------- bookkeeping ----------------
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0] ref_mem [512];
   exp_t expq [$];
   int   cyc = 0;
   int   free_at = 0;   // first cycle number at which the arbiter can decide again
   int   starve = 0;

   initial begin
      exp_t e;
      bit   r0, r1;
      int   w;
      forever begin
         @(posedge clk);
         cyc++;
         if (!in_reset) begin
            free_at = 0;
            starve  = 0;
         end else if (cyc >= free_at) begin
            r0 = p_req[0];
            r1 = p_req[1];
            if (r0 || r1) begin
               w = (r1 && (!r0 || starve == LIM)) ? 1 : 0;
               if (r0 && r1 && w == 0) starve = (starve < LIM) ? starve + 1 : starve;
               else starve = 0;
               e.cyc   = cyc;
               e.port  = w;
               e.we    = p_we[w];
               e.addr  = p_addr[w];
               e.wdata = p_wdata[w];
               e.rdata = ref_mem[e.addr];
               if (e.we) ref_mem[e.addr] = e.wdata;
               expq.push_back(e);
               free_at = cyc + (e.we ? 2 : 3);
            end else begin
               starve = 0;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int            gnt_log [$];
   bit            pend = 1'b0;
   int            pend_port = 0;
   int            pend_cyc = 0;
   logic [DW-1:0] pend_data = '0;
   logic [DW-1:0] last_rd [2];

   initial begin
      exp_t e;
      int   rv_port;
      last_rd[0] = '0;
      last_rd[1] = '0;
      forever begin
         @(negedge clk);
         if (!in_reset) begin
            expq.delete();
            pend = 1'b0;
            last_rd[0] = '0;
            last_rd[1] = '0;
            chk("rst_ctl", {gnt[0], gnt[1], rvalid[0], rvalid[1], mem_we, mem_re, busy}, '0);
            chk("rst_mem", {mem_addr, mem_wdata}, '0);
            chk("rst_rdata", {rdata[0], rdata[1]}, '0);
            continue;
         end
         chk("we_re_excl", mem_we & mem_re, 0);
         chk("one_gnt", gnt[0] & gnt[1], 0);
         chk("busy", busy, (cyc < free_at - 1));
         chk("starve_cnt", u_dut.u_starve.cnt_reg, starve);

         rv_port = -1;
         if (pend && pend_cyc == cyc) begin
            chk("rvalid", {rvalid[1], rvalid[0]}, (pend_port == 1) ? 2'b10 : 2'b01);
            chk("rdata", rdata[pend_port], pend_data);
            last_rd[pend_port] = pend_data;
            rv_port = pend_port;
            pend = 1'b0;
         end else begin
            chk("no_rvalid", {rvalid[1], rvalid[0]}, 2'b00);
         end
         for (int p = 0; p < 2; p++) begin
            if (p != rv_port) chk("rdata_hold", rdata[p], last_rd[p]);
         end

         if (gnt[0]) gnt_log.push_back(0);
         if (gnt[1]) gnt_log.push_back(1);
         if (expq.size() > 0 && expq[0].cyc == cyc) begin
            e = expq.pop_front();
            chk("gnt_port", {gnt[1], gnt[0]}, (e.port == 1) ? 2'b10 : 2'b01);
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_strobe", {mem_we, mem_re}, e.we ? 2'b10 : 2'b01);
            if (e.we) begin
               chk("mem_wdata", mem_wdata, e.wdata);
            end else begin
               pend      = 1'b1;
               pend_port = e.port;
               pend_data = e.rdata;
               pend_cyc  = cyc + 1;
            end
         end else begin
            chk("no_gnt", {gnt[1], gnt[0]}, 2'b00);
         end
      end
   end

   // ---------------- drivers ----------------
   // Called at posedge+#1; returns at posedge+#1 after the grant cycle.
   task automatic issue(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit got;
      got = 1'b0;
      p_we[p] = we; p_addr[p] = a; p_wdata[p] = d; p_req[p] = 1'b1;
      for (int k = 0; k < 80 && !got; k++) begin
         @(negedge clk);
         if (gnt[p]) got = 1'b1;
      end
      chk("gnt_arrives", got, 1'b1);
      @(posedge clk); #1;
      p_req[p] = 1'b0;
   endtask

   // One-cycle request that may or may not be granted.
   task automatic blip(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      p_we[p] = we; p_addr[p] = a; p_wdata[p] = d; p_req[p] = 1'b1;
      @(posedge clk); #1;
      p_req[p] = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic rand_port(input int p, input int n);
      int            gap;
      logic [AW-1:0] a;
      for (int i = 0; i < n; i++) begin
         gap = $urandom_range(0, 3);
         idle_cycles(gap);
         a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) blip(p, 1'($urandom_range(0, 1)), a, $urandom);
         else issue(p, 1'($urandom_range(0, 1)), a, $urandom);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int exp_order [10];
      int ones;
      bit got;
      exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      for (int p = 0; p < 2; p++) begin
         p_req[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
      end

      // preload RAM while held in reset
      for (int a = 0; a < 512; a++) begin
         @(negedge clk);
         ld_en   = 1'b1;
         ld_addr = AW'(a);
         ld_data = (a == 511) ? 32'h12345678 : $urandom;
         ref_mem[a] = ld_data;
      end
      @(negedge clk);
      ld_en = 1'b0;
      @(posedge clk); #1;
      in_reset = 1'b1;
      idle_cycles(2);

      // 1: p0 write then read back
      issue(0, 1'b1, 9'h010, 32'hDEADBEEF);
      chk("t1_busy_after_write", {busy, mem_we}, 2'b00);
      issue(0, 1'b0, 9'h010, '0);
      chk("t1_rvalid", rvalid[0], 1'b1);
      chk("t1_rdata", rdata[0], 32'hDEADBEEF);
      idle_cycles(2);

      // 3: p1 alone reads 1FF
      issue(1, 1'b0, 9'h1FF, '0);
      chk("t3_rvalid", rvalid[1], 1'b1);
      chk("t3_rdata", rdata[1], 32'h12345678);
      chk("t3_p0_rdata_kept", rdata[0], 32'hDEADBEEF);
      idle_cycles(2);

      // 2: continuous contention, starvation release every 5th grant
      gnt_log.delete();
      fork
         begin
            for (int i = 0; i < 10; i++) issue(0, 1'b0, AW'($urandom_range(0, 31)), '0);
         end
         begin
            for (int i = 0; i < 2; i++) issue(1, 1'b0, AW'($urandom_range(32, 63)), '0);
         end
      join
      chk("t2_log_len", gnt_log.size() >= 10, 1'b1);
      for (int i = 0; i < 10 && i < gnt_log.size(); i++) chk("t2_gnt_order", gnt_log[i], exp_order[i]);
      idle_cycles(2);

      // 5: p1 loses once, then pulses req during p0's RDATA and is dropped
      gnt_log.delete();
      fork
         issue(0, 1'b0, 9'h020, '0);
         begin
            blip(1, 1'b0, 9'h030, '0);
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
               @(negedge clk);
               if (gnt[0]) got = 1'b1;
            end
            chk("t5_p0_gnt", got, 1'b1);
            @(posedge clk); #1;
            p_req[1] = 1'b1;
            @(posedge clk); #1;
            p_req[1] = 1'b0;
            chk("t5_starve_mid", u_dut.u_starve.cnt_reg, 1);
         end
      join
      idle_cycles(3);
      ones = 0;
      foreach (gnt_log[i]) if (gnt_log[i] == 1) ones++;
      chk("t5_no_p1_gnt", ones, 0);
      chk("t5_starve_clear", u_dut.u_starve.cnt_reg, 0);

      // random two-port traffic
      fork
         rand_port(0, 40);
         rand_port(1, 40);
      join
      idle_cycles(4);

      // 4: reset during ACCESS of a read
      p_we[0] = 1'b0; p_addr[0] = 9'h011; p_req[0] = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (gnt[0]) got = 1'b1;
      end
      chk("t4_gnt", got, 1'b1);
      #1;
      in_reset = 1'b0;
      p_req[0] = 1'b0;
      #1;
      chk("t4_outputs_cleared", {gnt[0], gnt[1], rvalid[0], rvalid[1], mem_we, mem_re, busy}, '0);
      @(posedge clk);
      @(negedge clk);
      @(posedge clk); #1;
      in_reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t4_no_rvalid", {rvalid[0], rvalid[1]}, 2'b00);
      end
      @(posedge clk); #1;
      issue(0, 1'b0, 9'h1FF, '0);
      chk("t4_rvalid_after", rvalid[0], 1'b1);
      chk("t4_rdata_after", rdata[0], 32'h12345678);

      idle_cycles(4);
      chk("drain", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
